// File: rtl/JZJCoreFTypes.sv
// rtl/JZJCoreFTypes.sv - shared core types: memory modes, funct3 width codes, latched load lane
// Also hosts the access-fault rule used by the memory access unit.
package JZJCoreFTypes;

  typedef enum logic [1:0] {
    NOP           = 2'd0,
    LOAD          = 2'd1,
    STORE_PRELOAD = 2'd2,
    STORE         = 2'd3
  } MemoryMode_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [1:0] offset;
    logic [2:0] funct3;
  } lane_t;

  localparam lane_t LANE_RESET = '{offset: 2'd0, funct3: F3_W};

  // Misaligned halfword/word or a width code the mode does not support.
  function automatic logic access_faults(input MemoryMode_t mode, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic fault;
    fault = 1'b0;
    case (mode)
      LOAD: begin
        case (f3)
          F3_B, F3_BU: fault = 1'b0;
          F3_H, F3_HU: fault = off[0];
          F3_W:        fault = |off;
          default:     fault = 1'b1;
        endcase
      end
      STORE_PRELOAD, STORE: begin
        case (f3)
          F3_B:    fault = 1'b0;
          F3_H:    fault = off[0];
          F3_W:    fault = |off;
          default: fault = 1'b1;
        endcase
      end
      default: fault = 1'b0;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - combinational store lane merge and load lane extract/extend
module byte_lane_unit
  import JZJCoreFTypes::*;
(
  input  logic [31:0] preload_word_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  store_offset_i,
  input  logic [2:0]  store_funct3_i,
  input  logic [31:0] read_word_i,
  input  lane_t       load_lane_i,
  output logic [31:0] store_word_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    store_word_o = preload_word_i;
    case (store_funct3_i)
      F3_B:    store_word_o[{store_offset_i, 3'b000} +: 8] = store_data_i[7:0];
      F3_H:    store_word_o[{store_offset_i[1], 4'b0000} +: 16] = store_data_i[15:0];
      default: store_word_o = store_data_i;
    endcase
  end

  assign load_byte = read_word_i[{load_lane_i.offset, 3'b000} +: 8];
  assign load_half = read_word_i[{load_lane_i.offset[1], 4'b0000} +: 16];

  always_comb begin
    case (load_lane_i.funct3)
      F3_B:    load_data_o = {{24{load_byte[7]}}, load_byte};
      F3_BU:   load_data_o = {24'h000000, load_byte};
      F3_H:    load_data_o = {{16{load_half[15]}}, load_half};
      F3_HU:   load_data_o = {16'h0000, load_half};
      default: load_data_o = read_word_i;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - word RAM with byte/halfword loads and read-merge-write stores
// Define MEMORY_ACCESS_STATS_EN to build the load/store counters.
module memory_access_unit
  import JZJCoreFTypes::*;
#(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  MemoryMode_t memory_mode,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] rs2,
  output logic [31:0] rd_data,
  output logic        unaligned_access,
  output logic [31:0] load_count,
  output logic [31:0] store_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   read_q, read_d;
  logic [31:0]   preload_q, preload_d;
  logic [31:0]   store_word;
  lane_t         lane_q, lane_d;
  logic [AW-1:0] word_idx;
  logic          access_ok;
  logic          ram_we;
  logic          unused_addr_bits;

  // Upper address bits alias onto the same words.
  assign word_idx         = address[AW+1:2];
  assign unused_addr_bits = ^address[31:AW+2];

  assign unaligned_access = access_faults(memory_mode, funct3, address[1:0]);
  assign access_ok        = !unaligned_access;
  assign ram_we           = !reset && access_ok && (memory_mode == STORE);

  always_comb begin
    read_d    = read_q;
    preload_d = preload_q;
    lane_d    = lane_q;
    if (access_ok) begin
      case (memory_mode)
        LOAD: begin
          read_d = mem_q[word_idx];
          lane_d = '{offset: address[1:0], funct3: funct3};
        end
        STORE_PRELOAD: preload_d = mem_q[word_idx];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_q    <= '0;
      preload_q <= '0;
      lane_q    <= LANE_RESET;
    end else begin
      read_q    <= read_d;
      preload_q <= preload_d;
      lane_q    <= lane_d;
    end
  end

  // RAM has no reset; contents survive it.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem_q[word_idx] <= store_word;
    end
  end

  byte_lane_unit u_lanes (
    .preload_word_i (preload_q),
    .store_data_i   (rs2),
    .store_offset_i (address[1:0]),
    .store_funct3_i (funct3),
    .read_word_i    (read_q),
    .load_lane_i    (lane_q),
    .store_word_o   (store_word),
    .load_data_o    (rd_data)
  );

`ifdef MEMORY_ACCESS_STATS_EN
  MemoryMode_t last_mode_q;
  logic [31:0] load_count_q, load_count_d;
  logic [31:0] store_count_q, store_count_d;

  // A multi-cycle load counts once: only its first LOAD edge increments.
  always_comb begin
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    if (access_ok && (memory_mode == LOAD) && (last_mode_q != LOAD)) begin
      load_count_d = load_count_q + 32'd1;
    end
    if (access_ok && (memory_mode == STORE)) begin
      store_count_d = store_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_mode_q   <= NOP;
      load_count_q  <= '0;
      store_count_q <= '0;
    end else begin
      last_mode_q   <= memory_mode;
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
    end
  end

  assign load_count  = load_count_q;
  assign store_count = store_count_q;
`else
  assign load_count  = '0;
  assign store_count = '0;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - scoreboard bench: directed scenarios then randomized traffic
module tb_memory_access_unit;
  import JZJCoreFTypes::*;

  localparam int DEPTH = 4096;
`ifdef MEMORY_ACCESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  MemoryMode_t memory_mode;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] rs2;
  logic [31:0] rd_data;
  logic        unaligned_access;
  logic [31:0] load_count;
  logic [31:0] store_count;

  memory_access_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .memory_mode      (memory_mode),
    .funct3           (funct3),
    .address          (address),
    .rs2              (rs2),
    .rd_data          (rd_data),
    .unaligned_access (unaligned_access),
    .load_count       (load_count),
    .store_count      (store_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rd;
    logic        flag;
    logic [31:0] lc;
    logic [31:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state
  logic [31:0] m_mem [int];
  logic [31:0] m_read, m_preload;
  logic [1:0]  m_off;
  logic [2:0]  m_f3;
  logic [31:0] m_loads, m_stores;
  MemoryMode_t m_last;

  function automatic bit model_fault(MemoryMode_t mode, logic [2:0] f3, logic [31:0] addr);
    int size;
    if (mode == NOP) return 1'b0;
    if (mode == LOAD) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    end else if (!(f3 inside {3'd0, 3'd1, 3'd2})) begin
      return 1'b1;
    end
    size = 1 << f3[1:0];
    return (int'(addr[1:0]) % size) != 0;
  endfunction

  function automatic logic [31:0] model_extract(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
    int v;
    case (f3)
      3'd0: begin v = int'((w >> (8 * off)) & 32'hFF); if (v > 127) v -= 256; return 32'(v); end
      3'd4: return (w >> (8 * off)) & 32'hFF;
      3'd1: begin v = int'((w >> (8 * off)) & 32'hFFFF); if (v > 32767) v -= 65536; return 32'(v); end
      3'd5: return (w >> (8 * off)) & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic void model_reset();
    m_read = 0; m_preload = 0; m_off = 0; m_f3 = 3'd2;
    m_loads = 0; m_stores = 0; m_last = NOP;
  endfunction

  function automatic bit model_step(MemoryMode_t mode, logic [2:0] f3, logic [31:0] addr,
                                    logic [31:0] data);
    bit          fault;
    int          idx, nbytes, lane;
    logic [31:0] w;
    fault = model_fault(mode, f3, addr);
    idx   = int'((addr >> 2) % DEPTH);
    if (!fault) begin
      case (mode)
        LOAD: begin
          m_read = m_mem[idx]; m_off = addr[1:0]; m_f3 = f3;
          if (m_last != LOAD) m_loads++;
        end
        STORE_PRELOAD: m_preload = m_mem[idx];
        STORE: begin
          if (f3 == 3'd2) begin
            m_mem[idx] = data;
          end else begin
            w = m_preload;
            nbytes = (f3 == 3'd0) ? 1 : 2;
            for (int k = 0; k < nbytes; k++) begin
              lane = int'(addr[1:0]) + k;
              w = (w & ~(32'hFF << (8 * lane))) | (((data >> (8 * k)) & 32'hFF) << (8 * lane));
            end
            m_mem[idx] = w;
          end
          m_stores++;
        end
        default: ;
      endcase
    end
    m_last = mode;
    return fault;
  endfunction

  function automatic void push_expect(bit fault, string tag);
    exp_t e;
    e.rd   = model_extract(m_read, m_off, m_f3);
    e.flag = fault;
    e.lc   = STATS ? m_loads : 32'd0;
    e.sc   = STATS ? m_stores : 32'd0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endfunction

  task automatic do_op(input MemoryMode_t mode, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input string tag);
    bit fault;
    @(negedge clock);
    reset = 1'b0;
    memory_mode = mode; funct3 = f3; address = addr; rs2 = data;
    fault = model_step(mode, f3, addr, data);
    push_expect(fault, tag);
  endtask

  task automatic do_reset_op(input MemoryMode_t mode, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input string tag);
    @(negedge clock);
    reset = 1'b1;
    memory_mode = mode; funct3 = f3; address = addr; rs2 = data;
    model_reset();
    push_expect(model_fault(mode, f3, addr), tag);
  endtask

  task automatic check(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s actual=%h required=%h", tag, what, act, req);
    end
  endtask

  // Monitor: every output sample consumes one expectation
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, "rd_data", rd_data, e.rd);
        check(t, "unaligned_access", {31'd0, unaligned_access}, {31'd0, e.flag});
        check(t, "load_count", load_count, e.lc);
        check(t, "store_count", store_count, e.sc);
      end
    end
  end

  initial begin
    MemoryMode_t mode;
    logic [2:0]  f3;
    logic [31:0] addr;
    reset = 1'b1;
    memory_mode = NOP; funct3 = 3'd2; address = 0; rs2 = 0;
    model_reset();
    repeat (2) @(posedge clock);

    do_op(NOP, F3_W, 32'h0, 32'h0, "reset_state");
    do_op(STORE, F3_W, 32'h100, 32'hDEADBEEF, "sw_100");
    do_op(LOAD, F3_W, 32'h100, 32'h0, "lw_100_c1");
    do_op(LOAD, F3_W, 32'h100, 32'h0, "lw_100_c2");
    do_op(STORE_PRELOAD, F3_B, 32'h101, 32'h0, "preload_101");
    do_op(STORE, F3_B, 32'h101, 32'h55, "sb_101");
    do_op(LOAD, F3_B, 32'h101, 32'h0, "lb_101");
    do_op(LOAD, F3_BU, 32'h103, 32'h0, "lbu_103");
    do_op(NOP, F3_W, 32'h0, 32'h0, "nop_hold");
    do_op(LOAD, F3_B, 32'h103, 32'h0, "lb_103");
    do_op(LOAD, F3_H, 32'h102, 32'h0, "lh_102");
    do_op(LOAD, F3_HU, 32'h102, 32'h0, "lhu_102");
    do_op(LOAD, F3_H, 32'h101, 32'h0, "lh_101_unaligned");
    do_op(STORE, F3_W, 32'h102, 32'hFFFFFFFF, "sw_102_unaligned");
    do_op(LOAD, F3_W, 32'h100, 32'h0, "lw_100_after_bad_sw");
    do_op(LOAD, 3'b011, 32'h100, 32'h0, "load_f3_011");
    do_op(STORE, 3'b100, 32'h100, 32'h0, "store_f3_100");
    do_op(STORE, F3_W, 32'h4000, 32'h12345678, "sw_4000_wrap");
    do_op(LOAD, F3_W, 32'h0, 32'h0, "lw_0_wrap");
    do_reset_op(STORE, F3_W, 32'h100, 32'hCAFEF00D, "reset_during_sw");
    do_op(LOAD, F3_W, 32'h100, 32'h0, "lw_100_after_reset");

    for (int i = 0; i < 8; i++) begin
      do_op(STORE, F3_W, 32'h200 + 32'(4 * i), $urandom, "rand_init");
    end
    for (int i = 0; i < 400; i++) begin
      mode = MemoryMode_t'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        f3 = 3'($urandom_range(0, 7));
      end else begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B;
          1: f3 = F3_H;
          2: f3 = F3_W;
          3: f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end
      addr = 32'h200 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom << 14);
      if (i == 200) begin
        do_reset_op(mode, f3, addr, $urandom, "rand_reset");
      end else begin
        do_op(mode, f3, addr, $urandom, "rand");
      end
    end

    @(negedge clock);
    memory_mode = NOP;
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending_expectations actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter: DEPTH_WORDS, default 4096, data RAM depth in 32-bit words (power of two).
REQ-002 clock  input  1  core clock; all RAM and register updates on posedge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 memory_mode  input  MemoryMode_t  NOP / LOAD / STORE_PRELOAD / STORE, driven by control logic.
REQ-005 funct3  input  3  width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu (stores: 000/001/010 only).
REQ-006 address  input  32  byte address (rs1 + immediate, formed upstream).
REQ-007 rs2  input  32  store data.
REQ-008 rd_data  output  32  load result, to RD source mux.
REQ-009 unaligned_access  output  1  error flag, to control logic halt input.
REQ-010 load_count, store_count  output  32 each  access statistics (see Configuration).

Function
REQ-011 Word index = address[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around), no error.
REQ-012 NOP: no RAM write, internal registers hold, unaligned_access = 0.
REQ-013 LOAD posedge: read addressed word into read_reg; latch address[1:0] and funct3 into lane_reg.
REQ-014 rd_data combinational from read_reg/lane_reg: byte/halfword selected by latched offset, sign-extended (b, h) or zero-extended (bu, hu); w passes through.
REQ-015 Load latency: rd_data valid after first LOAD posedge; repeated LOAD posedge on same address returns same value (second cycle of a 2-cycle load).
REQ-016 STORE_PRELOAD posedge: read addressed word into preload_reg; no RAM write.
REQ-017 STORE posedge, funct3 010: write rs2 to addressed word; preload_reg ignored.
REQ-018 STORE posedge, funct3 000/001: write preload_reg with lane(s) at address[1:0] replaced by rs2[7:0] / rs2[15:0].
REQ-019 unaligned_access combinational, mode != NOP only: h/hu/sh with address[0]=1; w/sw with address[1:0]!=0; any funct3 not listed in REQ-005 for the mode.
REQ-020 Flagged access: no RAM write, read_reg/preload_reg/lane_reg hold.
REQ-021 Read and write same word on consecutive posedges: read returns newly written data (no stale read).

Reset
REQ-022 Reset clears read_reg, preload_reg, lane_reg (offset 0, funct3 010), counters, last_mode register to NOP; rd_data = 0.
REQ-023 RAM contents unaffected by reset; reset mid-access aborts it, no write occurs on the reset cycle.

Configuration
REQ-024 Macro MEMORY_ACCESS_STATS_EN.
REQ-025 Defined: load_count increments on each LOAD posedge where last_mode != LOAD and access not flagged; store_count increments on each non-flagged STORE posedge; both wrap at 2^32; last_mode registered each posedge.
REQ-026 Undefined: counters and last_mode not instantiated; load_count = store_count = 0 constantly.

Structure
REQ-027 MemoryMode_t and funct3 width codes live in the shared JZJCoreFTypes package; no new local enums.
REQ-028 Lane merge/extract logic in one combinational sub-module, byte_lane_unit (store merge + load extract).

Verification
REQ-029 sw 0xDEADBEEF @0x100 (STORE), then LOAD,LOAD lw @0x100 -> rd_data 0xDEADBEEF both cycles, load_count +1 (macro on).
REQ-030 After REQ-029: STORE_PRELOAD then STORE sb rs2=0x55 @0x101 -> word 0xDEAD55EF; lb @0x101 -> 0x00000055; lbu @0x103 -> 0x000000DE; lb @0x103 -> 0xFFFFFFDE.
REQ-031 lh @0x102 -> 0xFFFFDEAD; lhu @0x102 -> 0x0000DEAD; lh @0x101 -> unaligned_access=1, rd_data unchanged.
REQ-032 sw @0x102 -> unaligned_access=1, word @0x100 unchanged, store_count unchanged; funct3 011 LOAD -> flag=1.
REQ-033 DEPTH_WORDS=4096: sw 0x12345678 @0x4000 -> lw @0x0 returns 0x12345678 (wrap).
REQ-034 Assert reset during STORE cycle -> no write, rd_data 0, counters 0; RAM prior contents still readable.
